// File: rtl/minicpu_mem_pkg.sv
// Memory-side types and constants shared by the miniCPU core and its SRAM arbiter.
package minicpu_mem_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam logic [31:0] BOOT_PC    = 32'hC000_0000;

  // Width of the data-run counter; holds MAX_DATA_RUN values up to 15.
  localparam int unsigned RUN_W      = 4;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_INST = 2'd1,
    RESP_DATA = 2'd2
  } resp_owner_e;

endpackage

// File: rtl/unified_sram_arbiter_if.sv
// Bundle of the fetch port, data port and SRAM macro signals around the arbiter.
// Handshake: req is held until gnt is seen high in the same cycle; rvalid follows gnt by exactly one cycle and cannot be stalled.
interface unified_sram_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_gnt;
  logic              inst_rvalid;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_gnt;
  logic              data_rvalid;
  logic [DATA_W-1:0] data_rdata;

  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, sram_rdata,
    output inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, sram_rdata,
    input  inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata
  );

endinterface

// File: rtl/unified_sram_arbiter_fair_counter.sv
// Counts back-to-back data grants while a fetch waits and forces a fetch grant once the run limit is hit.
module arb_fair_counter
  import minicpu_mem_pkg::*;
#(
  parameter int unsigned MAX_DATA_RUN = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic inst_req,
  input  logic inst_gnt,
  input  logic data_gnt,
  output logic force_inst
);
  localparam logic [RUN_W-1:0] MAX_RUN = RUN_W'(MAX_DATA_RUN);

  logic [RUN_W-1:0] data_run_q;
  logic [RUN_W-1:0] data_run_d;

  // Decision uses only the registered count, so it never loops through the grant.
  assign force_inst = inst_req && (data_run_q == MAX_RUN);

  always_comb begin
    data_run_d = data_run_q;
    if (!inst_req || inst_gnt) begin
      data_run_d = '0;
    end else if (data_gnt && (data_run_q < MAX_RUN)) begin
      data_run_d = data_run_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) data_run_q <= '0;
    else         data_run_q <= data_run_d;
  end

endmodule

// File: rtl/unified_sram_arbiter.sv
// Shares one 1-cycle-latency SRAM between fetch and data ports; data wins unless a fetch has waited MAX_DATA_RUN grants.
// Build option ARB_STATS_EN adds saturating grant/conflict counters.
module unified_sram_arbiter
  import minicpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = MEM_ADDR_W,
  parameter int unsigned DATA_W       = MEM_DATA_W,
  parameter int unsigned MAX_DATA_RUN = 3
) (
  input  logic                     clk,
  input  logic                     resetn,
  unified_sram_arbiter_if.slave    bus,
`ifdef ARB_STATS_EN
  output logic [31:0]              stat_inst_grants,
  output logic [31:0]              stat_data_grants,
  output logic [31:0]              stat_conflicts,
`endif
  output resp_owner_e              resp_state
);
  logic              force_inst;
  logic              inst_gnt;
  logic              data_gnt;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  resp_owner_e state_q, state_d;
  logic        store_q, store_d;
  logic        inst_rvalid_q, data_rvalid_q;

  arb_fair_counter #(.MAX_DATA_RUN(MAX_DATA_RUN)) u_fair (
    .clk        (clk),
    .resetn     (resetn),
    .inst_req   (bus.inst_req),
    .inst_gnt   (inst_gnt),
    .data_gnt   (data_gnt),
    .force_inst (force_inst)
  );

  // Gating with resetn keeps every output at 0 while reset is asserted.
  assign inst_gnt = resetn & bus.inst_req & (~bus.data_req | force_inst);
  assign data_gnt = resetn & bus.data_req & ~inst_gnt;

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    if (inst_gnt) begin
      addr_mux = bus.inst_addr;
    end else if (data_gnt) begin
      addr_mux  = bus.data_addr;
      wdata_mux = bus.data_we ? bus.data_wdata : '0;
    end
  end

  assign bus.inst_gnt   = inst_gnt;
  assign bus.data_gnt   = data_gnt;
  assign bus.sram_en    = inst_gnt | data_gnt;
  assign bus.sram_we    = data_gnt & bus.data_we;
  assign bus.sram_addr  = addr_mux;
  assign bus.sram_wdata = wdata_mux;

  always_comb begin
    state_d = RESP_IDLE;
    if (inst_gnt)      state_d = RESP_INST;
    else if (data_gnt) state_d = RESP_DATA;
    store_d = data_gnt & bus.data_we;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= RESP_IDLE;
      store_q       <= 1'b0;
      inst_rvalid_q <= 1'b0;
      data_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      store_q       <= store_d;
      inst_rvalid_q <= (state_d == RESP_INST);
      data_rvalid_q <= (state_d == RESP_DATA);
    end
  end

  assign resp_state      = state_q;
  assign bus.inst_rvalid = inst_rvalid_q;
  assign bus.data_rvalid = data_rvalid_q;
  assign bus.inst_rdata  = inst_rvalid_q ? bus.sram_rdata : '0;
  assign bus.data_rdata  = (data_rvalid_q && !store_q) ? bus.sram_rdata : '0;

`ifdef ARB_STATS_EN
  logic [31:0] inst_cnt_q, inst_cnt_d;
  logic [31:0] data_cnt_q, data_cnt_d;
  logic [31:0] conf_cnt_q, conf_cnt_d;

  always_comb begin
    inst_cnt_d = inst_cnt_q;
    data_cnt_d = data_cnt_q;
    conf_cnt_d = conf_cnt_q;
    if (inst_gnt && (inst_cnt_q != '1)) inst_cnt_d = inst_cnt_q + 32'd1;
    if (data_gnt && (data_cnt_q != '1)) data_cnt_d = data_cnt_q + 32'd1;
    if (bus.inst_req && bus.data_req && (conf_cnt_q != '1)) conf_cnt_d = conf_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_cnt_q <= '0;
      data_cnt_q <= '0;
      conf_cnt_q <= '0;
    end else begin
      inst_cnt_q <= inst_cnt_d;
      data_cnt_q <= data_cnt_d;
      conf_cnt_q <= conf_cnt_d;
    end
  end

  assign stat_inst_grants = inst_cnt_q;
  assign stat_data_grants = data_cnt_q;
  assign stat_conflicts   = conf_cnt_q;
`endif

endmodule

// File: tb/tb_unified_sram_arbiter.sv
// Directed bench for unified_sram_arbiter with a behavioural 1-cycle SRAM.
module tb_unified_sram_arbiter;
  import minicpu_mem_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  resp_owner_e resp_state;
`ifdef ARB_STATS_EN
  logic [31:0] stat_inst_grants, stat_data_grants, stat_conflicts;
`endif

  unified_sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_sram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_RUN(3)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .bus              (bus),
`ifdef ARB_STATS_EN
    .stat_inst_grants (stat_inst_grants),
    .stat_data_grants (stat_data_grants),
    .stat_conflicts   (stat_conflicts),
`endif
    .resp_state       (resp_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // SRAM model: word i preloaded with 0x1000_0000 + 0x11*i, indexed by addr[5:2]
  logic [31:0] mem [16];
  logic        preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'h11 * i;
      preloaded <= 1'b1;
    end else if (bus.sram_en) begin
      if (bus.sram_we) mem[bus.sram_addr[5:2]] <= bus.sram_wdata;
      else             bus.sram_rdata <= mem[bus.sram_addr[5:2]];
    end
  end

  // checking
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_req   = 1'b0;
    bus.data_req   = 1'b0;
    bus.data_we    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ignt"},  64'(bus.inst_gnt),    64'd0);
    check({tag, "_dgnt"},  64'(bus.data_gnt),    64'd0);
    check({tag, "_en"},    64'(bus.sram_en),     64'd0);
    check({tag, "_we"},    64'(bus.sram_we),     64'd0);
    check({tag, "_addr"},  64'(bus.sram_addr),   64'd0);
    check({tag, "_wdata"}, 64'(bus.sram_wdata),  64'd0);
    check({tag, "_irv"},   64'(bus.inst_rvalid), 64'd0);
    check({tag, "_drv"},   64'(bus.data_rvalid), 64'd0);
    check({tag, "_ird"},   64'(bus.inst_rdata),  64'd0);
    check({tag, "_drd"},   64'(bus.data_rdata),  64'd0);
  endtask

  string pat = "DDDIDDDI";

  initial begin
    bus.inst_addr  = BOOT_PC;
    bus.data_addr  = 32'h0;
    bus.data_wdata = 32'h0;
    bus.data_we    = 1'b0;
    bus.inst_req   = 1'b1;
    bus.data_req   = 1'b1;
    #3;
    check_all_zero("rst");
    check("rst_state", 64'(resp_state), 64'(RESP_IDLE));
    idle_inputs();
    tick();
    tick();
    resetn = 1'b1;

    // fetch-only stream, no bubbles
    bus.inst_req = 1'b1; bus.inst_addr = BOOT_PC;
    @(negedge clk);
    check("f0_ignt", 64'(bus.inst_gnt), 64'd1);
    check("f0_dgnt", 64'(bus.data_gnt), 64'd0);
    check("f0_addr", 64'(bus.sram_addr), 64'hC000_0000);
    tick();
    bus.inst_addr = BOOT_PC + 32'd4;
    @(negedge clk);
    check("f1_ignt", 64'(bus.inst_gnt), 64'd1);
    check("f1_irv",  64'(bus.inst_rvalid), 64'd1);
    check("f1_ird",  64'(bus.inst_rdata), 64'h1000_0000);
    tick();
    bus.inst_addr = BOOT_PC + 32'd8;
    @(negedge clk);
    check("f2_addr", 64'(bus.sram_addr), 64'hC000_0008);
    check("f2_irv",  64'(bus.inst_rvalid), 64'd1);
    check("f2_ird",  64'(bus.inst_rdata), 64'h1000_0011);
    tick();
    bus.inst_req = 1'b0;
    @(negedge clk);
    check("f3_en",  64'(bus.sram_en), 64'd0);
    check("f3_irv", 64'(bus.inst_rvalid), 64'd1);
    check("f3_ird", 64'(bus.inst_rdata), 64'h1000_0022);
    tick();
    @(negedge clk);
    check("f4_irv", 64'(bus.inst_rvalid), 64'd0);
    check("f4_ird", 64'(bus.inst_rdata), 64'd0);
    tick();

    // both requests held: D,D,D,I,D,D,D,I
    bus.inst_req = 1'b1; bus.inst_addr = BOOT_PC;
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h8;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("c%0d_dgnt", i), 64'(bus.data_gnt), 64'(pat[i] == "D"));
      check($sformatf("c%0d_ignt", i), 64'(bus.inst_gnt), 64'(pat[i] == "I"));
      if (i > 0) begin
        check($sformatf("c%0d_drv", i), 64'(bus.data_rvalid), 64'(pat[i-1] == "D"));
        check($sformatf("c%0d_irv", i), 64'(bus.inst_rvalid), 64'(pat[i-1] == "I"));
        check($sformatf("c%0d_drd", i), 64'(bus.data_rdata),
              (pat[i-1] == "D") ? 64'h1000_0022 : 64'd0);
        check($sformatf("c%0d_ird", i), 64'(bus.inst_rdata),
              (pat[i-1] == "I") ? 64'h1000_0000 : 64'd0);
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    check("c8_irv", 64'(bus.inst_rvalid), 64'd1);
    check("c8_drv", 64'(bus.data_rvalid), 64'd0);
    check("c8_ird", 64'(bus.inst_rdata), 64'h1000_0000);
    tick();

    // store then load of the same word
    bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_addr = 32'h10; bus.data_wdata = 32'h37;
    @(negedge clk);
    check("st_dgnt",  64'(bus.data_gnt), 64'd1);
    check("st_we",    64'(bus.sram_we), 64'd1);
    check("st_addr",  64'(bus.sram_addr), 64'h10);
    check("st_wdata", 64'(bus.sram_wdata), 64'h37);
    tick();
    bus.data_we = 1'b0; bus.data_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("ld_we",    64'(bus.sram_we), 64'd0);
    check("ld_wdata", 64'(bus.sram_wdata), 64'd0);
    check("ack_drv",  64'(bus.data_rvalid), 64'd1);
    check("ack_drd",  64'(bus.data_rdata), 64'd0);
    check("ack_state", 64'(resp_state), 64'(RESP_DATA));
    tick();
    idle_inputs();
    @(negedge clk);
    check("ld_drv", 64'(bus.data_rvalid), 64'd1);
    check("ld_drd", 64'(bus.data_rdata), 64'h37);
    tick();

    // no requests
    @(negedge clk);
    check_all_zero("idle");
    tick();

    // reset in the cycle after a load grant drops the response
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h4;
    @(negedge clk);
    check("rl_dgnt", 64'(bus.data_gnt), 64'd1);
    tick();
    bus.data_req = 1'b0;
    bus.inst_req = 1'b1;
    resetn = 1'b0;
    #1;
    check_all_zero("rl_mid");
    @(negedge clk);
    check_all_zero("rl_neg");
    tick();
    bus.inst_req = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    check("rl_post_drv", 64'(bus.data_rvalid), 64'd0);
    check("rl_post_state", 64'(resp_state), 64'(RESP_IDLE));
    tick();
    bus.inst_req = 1'b1; bus.inst_addr = BOOT_PC + 32'd4;
    @(negedge clk);
    check("rl_ignt", 64'(bus.inst_gnt), 64'd1);
    tick();
    bus.inst_req = 1'b0;
    @(negedge clk);
    check("rl_irv", 64'(bus.inst_rvalid), 64'd1);
    check("rl_ird", 64'(bus.inst_rdata), 64'h1000_0011);
    tick();

`ifdef ARB_STATS_EN
    // 5 conflict cycles (D,D,D,I,D) then one fetch-only cycle
    resetn = 1'b0;
    #2;
    check("stat_rst", 64'(stat_conflicts), 64'd0);
    resetn = 1'b1;
    bus.inst_req = 1'b1; bus.data_req = 1'b1; bus.inst_addr = BOOT_PC; bus.data_addr = 32'h8;
    repeat (5) tick();
    bus.data_req = 1'b0;
    tick();
    idle_inputs();
    @(negedge clk);
    check("stat_conf", 64'(stat_conflicts), 64'd5);
    check("stat_data", 64'(stat_data_grants), 64'd4);
    check("stat_inst", 64'(stat_inst_grants), 64'd2);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
